ap_ctrl_sequencer: RTL and testbench
====================================

AP_CTRL_SEQUENCER -- requirements
Module: ap_ctrl_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of transaction counters and cfg_num_trans.
REQ-002 SHALL have parameter TIMEOUT, default 1024, idle cycles without any start/done acceptance before abort; TIMEOUT >= 2.
REQ-003 SHALL have ports in this order:
  clock           in   1      single clock, all logic on rising edge
  reset           in   1      asynchronous, active-low reset
  cfg_start       in   1      one-cycle request to begin a batch
  cfg_num_trans   in   CNT_W  number of transactions in the batch
  out_stall       in   1      downstream backpressure; withholds ap_continue
  ap_ready        in   1      DUT accepted current ap_start
  ap_done         in   1      DUT result valid; held until ap_continue
  ap_idle         in   1      DUT idle (status only)
  ap_start        out  1      start request to DUT
  ap_continue     out  1      result consumed / DUT may proceed
  busy            out  1      batch in progress
  finished        out  1      one-cycle pulse at batch end
  done_level      out  1      sticky batch-complete level
  start_cnt       out  CNT_W  starts accepted in current batch
  done_cnt        out  CNT_W  dones accepted in current batch
  err_timeout     out  1      sticky watchdog error
  err_proto       out  1      sticky protocol error

Function
REQ-004 SHALL implement states IDLE, RUN, DRAIN, FIN; state is registered.
REQ-005 SHALL, in IDLE on cfg_start with cfg_num_trans != 0: latch N = cfg_num_trans, clear start_cnt/done_cnt/done_level/err flags, enter RUN next cycle.
REQ-006 SHALL, in IDLE on cfg_start with cfg_num_trans == 0: stay IDLE, pulse finished the next cycle, set done_level, clear counters/err flags.
REQ-007 SHALL ignore cfg_start in any state other than IDLE.
REQ-008 SHALL drive ap_start = 1 (registered) in RUN while start_cnt < N; 0 in every other state.
REQ-009 SHALL count a start acceptance when ap_start && ap_ready in a cycle; start_cnt increments by 1 on the next edge.
REQ-010 SHALL deassert ap_start on the edge after the N-th acceptance; no extra start issued (zero-bubble back-to-back starts otherwise).
REQ-011 SHALL drive ap_continue = (state is RUN or DRAIN) && !out_stall, combinationally.
REQ-012 SHALL count a done acceptance when ap_done && ap_continue and done_cnt < start_cnt; done_cnt increments next edge.
REQ-013 SHALL, when ap_done && ap_continue with done_cnt == start_cnt (more dones than starts), set err_proto and not increment done_cnt.
REQ-014 SHALL count simultaneous start and done acceptances in the same cycle independently; a done with done_cnt == start_cnt in that cycle is still a protocol error.
REQ-015 SHALL transition RUN -> DRAIN when start_cnt reaches N and done_cnt < N; RUN/DRAIN -> FIN when done_cnt reaches N.
REQ-016 SHALL, in FIN, assert finished for exactly one cycle, set done_level, then return to IDLE.
REQ-017 SHALL hold done_level until the next accepted cfg_start.
REQ-018 SHALL maintain a watchdog counter in RUN/DRAIN, cleared on any start or done acceptance and on entry to RUN; on reaching TIMEOUT set err_timeout and enter FIN (abort; finished pulses, done_level set).
REQ-019 SHALL assert busy = 1 in RUN, DRAIN and FIN, 0 in IDLE.
REQ-020 SHALL never wrap counters: N <= 2^CNT_W-1 so start_cnt, done_cnt never exceed N.
REQ-021 SHALL treat ap_idle as status only; it does not affect state transitions.

Reset
REQ-022 SHALL, on reset low (asynchronous), force state IDLE and ap_start, finished, done_level, busy, err_timeout, err_proto, start_cnt, done_cnt, watchdog, N to 0; ap_continue evaluates to 0.
REQ-023 SHALL, on reset mid-batch, abandon the batch without asserting finished; release is synchronous to clock.

Verification
REQ-024 N=3, ap_ready always 1, ap_done pulsed 2 cycles after each start, out_stall=0 -> ap_start high exactly 3 cycles, start_cnt=3, done_cnt=3, single finished pulse, done_level=1.
REQ-025 N=2, ap_ready delayed 4 cycles per start -> ap_start held until ready, exactly 2 acceptances, no spurious third start.
REQ-026 N=1, ap_done high with out_stall=1 for 5 cycles -> ap_continue=0, done_cnt=0 during stall; count to 1 and finish after stall drops.
REQ-027 N=2, DUT never asserts ap_ready, TIMEOUT=16 -> err_timeout=1 16 cycles after RUN entry, finished pulse, state IDLE.
REQ-028 ap_done asserted while start_cnt=0 in RUN -> err_proto=1, done_cnt stays 0; cfg_num_trans=0 -> immediate finished, no ap_start.
REQ-029 Reset low during DRAIN -> all outputs 0 asynchronously, no finished pulse; new batch after release completes normally.

Source files
------------

// File: rtl/ap_ctrl_sequencer.sv
// Batch sequencer for an ap_ctrl_chain style block: issues N ap_start handshakes,
// collects N ap_done handshakes, and reports completion, watchdog aborts and protocol errors.
module ap_ctrl_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_num_trans,
    input  logic             out_stall,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_idle,
    output logic             ap_start,
    output logic             ap_continue,
    output logic             busy,
    output logic             finished,
    output logic             done_level,
    output logic [CNT_W-1:0] start_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic             err_timeout,
    output logic             err_proto
);

    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] TO_VAL = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] n_q, n_nxt;
    logic [CNT_W-1:0] start_cnt_nxt, done_cnt_nxt;
    logic [WD_W-1:0]  wdog, wdog_nxt;
    logic             ap_start_nxt, finished_nxt, done_level_nxt;
    logic             err_timeout_nxt, err_proto_nxt;
    logic             start_acc, done_acc, done_ok;
    logic             unused_idle;

    assign unused_idle = ap_idle;

    assign ap_continue = ((state == RUN) || (state == DRAIN)) && !out_stall;
    assign busy        = (state != IDLE);
    assign start_acc   = ap_start && ap_ready;
    assign done_acc    = ap_done && ap_continue;
    // A done with no outstanding start is rejected and flagged, never counted.
    assign done_ok     = done_acc && (done_cnt < start_cnt);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nxt       = state;
        n_nxt           = n_q;
        start_cnt_nxt   = start_cnt;
        done_cnt_nxt    = done_cnt;
        wdog_nxt        = wdog;
        finished_nxt    = 1'b0;
        done_level_nxt  = done_level;
        err_timeout_nxt = err_timeout;
        err_proto_nxt   = err_proto;

        case (state)
            IDLE: begin
                if (cfg_start) begin
                    n_nxt           = cfg_num_trans;
                    start_cnt_nxt   = '0;
                    done_cnt_nxt    = '0;
                    wdog_nxt        = '0;
                    err_timeout_nxt = 1'b0;
                    err_proto_nxt   = 1'b0;
                    if (cfg_num_trans == '0) begin
                        finished_nxt   = 1'b1;
                        done_level_nxt = 1'b1;
                    end else begin
                        done_level_nxt = 1'b0;
                        state_nxt      = RUN;
                    end
                end
            end
            RUN, DRAIN: begin
                start_cnt_nxt = start_cnt + CNT_W'(start_acc);
                done_cnt_nxt  = done_cnt + CNT_W'(done_ok);
                if (done_acc && !done_ok)
                    err_proto_nxt = 1'b1;
                if (start_acc || done_ok)
                    wdog_nxt = '0;
                else
                    wdog_nxt = wdog + WD_W'(1);

                // Completion wins over a watchdog expiry landing on the same cycle.
                if (done_cnt_nxt == n_q) begin
                    state_nxt      = FIN;
                    finished_nxt   = 1'b1;
                    done_level_nxt = 1'b1;
                end else if (wdog_nxt == TO_VAL) begin
                    state_nxt       = FIN;
                    finished_nxt    = 1'b1;
                    done_level_nxt  = 1'b1;
                    err_timeout_nxt = 1'b1;
                end else if (start_cnt_nxt == n_q) begin
                    state_nxt = DRAIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Registered ap_start looks ahead so back-to-back starts have no bubble.
        ap_start_nxt = (state_nxt == RUN) && (start_cnt_nxt < n_nxt);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            n_q         <= '0;
            start_cnt   <= '0;
            done_cnt    <= '0;
            wdog        <= '0;
            ap_start    <= 1'b0;
            finished    <= 1'b0;
            done_level  <= 1'b0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register samples pre-edge values.
            state       <= state_nxt;
            n_q         <= n_nxt;
            start_cnt   <= start_cnt_nxt;
            done_cnt    <= done_cnt_nxt;
            wdog        <= wdog_nxt;
            ap_start    <= ap_start_nxt;
            finished    <= finished_nxt;
            done_level  <= done_level_nxt;
            err_timeout <= err_timeout_nxt;
            err_proto   <= err_proto_nxt;
        end
    end

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed bench for ap_ctrl_sequencer: hand-timed handshake scenarios with
// expected cycle numbers computed from the batch protocol.
module tb_ap_ctrl_sequencer;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_start = 1'b0;
    logic [CNT_W-1:0] cfg_num_trans = '0;
    logic             out_stall = 1'b0;
    logic             ap_ready = 1'b0;
    logic             ap_done = 1'b0;
    logic             ap_idle = 1'b1;
    logic             ap_start, ap_continue, busy, finished, done_level;
    logic [CNT_W-1:0] start_cnt, done_cnt;
    logic             err_timeout, err_proto;

    int passed = 0;
    int total  = 0;
    int starts, fins, fin_cyc, err_cyc;

    ap_ctrl_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clock         (clock),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .cfg_num_trans (cfg_num_trans),
        .out_stall     (out_stall),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_start      (ap_start),
        .ap_continue   (ap_continue),
        .busy          (busy),
        .finished      (finished),
        .done_level    (done_level),
        .start_cnt     (start_cnt),
        .done_cnt      (done_cnt),
        .err_timeout   (err_timeout),
        .err_proto     (err_proto)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        ap_idle = ~ap_idle;
    endtask

    // Leaves the bench in cycle 1 of the batch (first cycle after the accepting edge).
    task automatic start_batch(input logic [CNT_W-1:0] n);
        cfg_start     = 1'b1;
        cfg_num_trans = n;
        step();
        cfg_start = 1'b0;
        starts    = 0;
        fins      = 0;
        fin_cyc   = 0;
        err_cyc   = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) step();
        check("rst_flags", {ap_start, ap_continue, busy, finished, done_level, err_timeout, err_proto}, 0);
        check("rst_cnts", {start_cnt, done_cnt}, 0);
        reset = 1'b1;
        step();

        // Three transactions, ready always high, done two cycles after each start.
        start_batch(3);
        check("A_busy", busy, 1);
        ap_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            ap_done   = (c >= 3 && c <= 5);
            cfg_start = (c == 2);
            cfg_num_trans = 5;
            #1;
            starts += ap_start;
            if (finished) begin fins++; fin_cyc = c; end
            step();
        end
        ap_done = 0; ap_ready = 0; cfg_start = 0;
        check("A_start_cycles", starts, 3);
        check("A_fin_pulses", fins, 1);
        check("A_fin_cycle", fin_cyc, 6);
        check("A_start_cnt", start_cnt, 3);
        check("A_done_cnt", done_cnt, 3);
        check("A_done_level", done_level, 1);
        check("A_idle_errs", {busy, err_timeout, err_proto}, 0);

        // Two transactions, ready arrives late; no third start may follow.
        start_batch(2);
        check("B_dl_cleared", done_level, 0);
        for (int c = 1; c <= 13; c++) begin
            ap_ready = (c == 4 || c >= 8);
            ap_done  = (c == 6 || c == 10);
            #1;
            if (c == 5) check("B_start_cnt_mid", start_cnt, 1);
            starts += ap_start;
            if (finished) begin fins++; fin_cyc = c; end
            step();
        end
        ap_ready = 0; ap_done = 0;
        check("B_start_cycles", starts, 8);
        check("B_start_cnt", start_cnt, 2);
        check("B_done_cnt", done_cnt, 2);
        check("B_fin_cycle", fin_cyc, 11);
        check("B_fin_pulses", fins, 1);

        // One transaction, done held through five stalled cycles.
        start_batch(1);
        for (int c = 1; c <= 10; c++) begin
            ap_ready  = (c == 1);
            ap_done   = (c >= 3 && c <= 8);
            out_stall = (c >= 3 && c <= 7);
            #1;
            if (c >= 3 && c <= 7) begin
                check("C_cont_stall", ap_continue, 0);
                check("C_done_cnt_stall", done_cnt, 0);
            end
            if (c == 8) check("C_cont_release", ap_continue, 1);
            if (finished) begin fins++; fin_cyc = c; end
            step();
        end
        ap_ready = 0; ap_done = 0; out_stall = 0;
        check("C_done_cnt", done_cnt, 1);
        check("C_fin_cycle", fin_cyc, 9);
        check("C_fin_pulses", fins, 1);

        // Ready never comes: watchdog aborts 16 cycles after RUN entry.
        start_batch(2);
        for (int c = 1; c <= 18; c++) begin
            #1;
            if (c == 16) check("D_pre_timeout", {busy, err_timeout}, 2'b10);
            if (err_timeout && err_cyc == 0) err_cyc = c;
            if (finished) begin fins++; fin_cyc = c; end
            step();
        end
        check("D_err_cycle", err_cyc, 17);
        check("D_fin_cycle", fin_cyc, 17);
        check("D_end_state", {busy, ap_start, done_level, err_timeout}, 4'b0011);
        check("D_start_cnt", start_cnt, 0);

        // Done together with the very first start: protocol error, done not counted.
        start_batch(1);
        check("E_err_to_clr", err_timeout, 0);
        for (int c = 1; c <= 6; c++) begin
            ap_ready = (c == 1);
            ap_done  = (c == 1 || c == 3);
            #1;
            if (c == 2) begin
                check("E_proto", err_proto, 1);
                check("E_done_cnt_held", done_cnt, 0);
                check("E_start_cnt", start_cnt, 1);
            end
            if (finished) begin fins++; fin_cyc = c; end
            step();
        end
        ap_ready = 0; ap_done = 0;
        check("E_done_cnt", done_cnt, 1);
        check("E_fin_cycle", fin_cyc, 4);
        check("E_proto_sticky", err_proto, 1);

        // Zero-length batch finishes at once without any start.
        start_batch(0);
        #1;
        check("Z_fin", {finished, done_level, busy, ap_start, err_proto}, 5'b11000);
        check("Z_cnts", {start_cnt, done_cnt}, 0);
        step();
        check("Z_after", {finished, done_level}, 2'b01);

        // Reset in DRAIN: outputs drop immediately, no finished pulse.
        start_batch(2);
        ap_ready = 1'b1;
        step();
        step();
        ap_ready = 1'b0;
        #1;
        check("F_drain", {start_cnt, ap_start, busy, ap_continue}, {16'd2, 3'b011});
        step();
        reset = 1'b0;
        #1;
        check("F_rst_flags", {ap_start, ap_continue, busy, finished, done_level, err_timeout, err_proto}, 0);
        check("F_rst_cnts", {start_cnt, done_cnt}, 0);
        fins = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            fins += finished;
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            fins += finished;
        end
        check("F_no_fin", fins, 0);

        start_batch(1);
        for (int c = 1; c <= 6; c++) begin
            ap_ready = (c == 1);
            ap_done  = (c == 3);
            #1;
            if (finished) begin fins++; fin_cyc = c; end
            step();
        end
        ap_ready = 0; ap_done = 0;
        check("F_new_fin_cycle", fin_cyc, 4);
        check("F_new_done", {done_cnt, done_level}, {16'd1, 1'b1});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
